vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing and test-pattern generator, the next generation of the project's fixed 800x480 grid generator. Driven by `pixel_clk`, it produces HS/VS/BLANK/RGB on a `video_if` master port. It adds configurable porches and sync polarities, a frame-synchronous pattern selector, an external-pixel pass-through mode with a one-cycle-ahead request, and frame/line markers. It sits between the pixel clock domain and the video DAC/LCD interface.

## Interface
- `HDISP`, 800, active pixels per line
- `VDISP`, 480, active lines per frame
- `HFP`, 40 / `HPULSE`, 48 / `HBP`, 40: horizontal front porch, sync and back porch, in pixels
- `VFP`, 12 / `VPULSE`, 3 / `VBP`, 40: vertical front porch, sync and back porch, in lines
- `HS_POL`, 0: HS active level (0 = active-low)
- `VS_POL`, 0: VS active level
- `GRID`, 16: grid pitch; must be a power of 2
- Derived: HTOTAL = HDISP+HFP+HPULSE+HBP, VTOTAL = VDISP+VFP+VPULSE+VBP, HSUP = HFP+HPULSE+HBP, VSUP = VFP+VPULSE+VBP.

Ports:
- `pixel_clk`, in, 1: the only clock. It is forwarded unchanged to `video_ifm.CLK`.
- `pixel_rst_n`, in, 1: reset, asynchronous and active-low.
- `pattern_sel`, in, 2: pattern select. 0 = grid, 1 = colour bars, 2 = gray ramp, 3 = external.
- `fg_color`, in, 24: grid line colour, {R,G,B}.
- `ext_rgb`, in, 24: external pixel, sampled in any cycle where `pixel_req`=1.
- `pixel_req`, out, 1: the current counter position is active; external pixel wanted now.
- `req_x`, out, $clog2(HDISP): x of the requested pixel.
- `req_y`, out, $clog2(VDISP): y of the requested pixel.
- `frame_start`, out, 1: one-cycle pulse aligned with the output of counter position (0,0).
- `line_start`, out, 1: one-cycle pulse aligned with the output of every h=0.
- `video_ifm`, video_if.master: carries CLK, HS, VS, BLANK, RGB[23:0].

## Operation
- Counters:
  - `h_cnt` runs 0..HTOTAL-1 and wraps.
  - `v_cnt` increments when `h_cnt`=HTOTAL-1 and wraps to 0 at VTOTAL-1. There is no VTOTAL state.
- Line layout, in h_cnt order: front porch [0,HFP), sync [HFP,HFP+HPULSE), back porch, then active [HSUP,HTOTAL). The vertical layout is identical using the V parameters.
- Active region: h_cnt≥HSUP and v_cnt≥VSUP. In that region:
  - `pixel_req`=1
  - `req_x` = h_cnt−HSUP
  - `req_y` = v_cnt−VSUP
  - Outside it, `pixel_req`=0 and `req_x`/`req_y` are 0.
  - These three outputs are combinational from the counters.
- Pattern and colour latching: `pattern_sel` and `fg_color` are captured into internal registers only in the cycle where h_cnt=0 and v_cnt=0. They never change mid-frame. The reset value of the captured pattern is 0 (grid) and of the captured colour is 24'hFFFFFF.
- Patterns, evaluated at (req_x, req_y) and producing a 24-bit colour:
  - **Grid:** captured fg_color if req_x%GRID==0 or req_y%GRID==0, else 0.
  - **Bars:** bar index = req_x/(HDISP/8), clamped to 7. Colours in index order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - **Gray ramp:** R=G=B=req_x[7:0].
  - **External:** ext_rgb.
- Output register stage: HS, VS, BLANK, RGB, frame_start and line_start are all registered from the current counter values.
  - HS = HS_POL while h_cnt is in sync, else ~HS_POL. VS uses the same rule with the vertical counter and VS_POL.
  - BLANK = 1 in the active region, else 0.
  - RGB = pattern colour in the active region, else 0.

## Timing
- Reset, while `pixel_rst_n`=0, holds:
  - counters = 0
  - HS = ~HS_POL, VS = ~VS_POL
  - BLANK = 0, RGB = 0
  - frame_start = 0, line_start = 0
  - captured pattern/colour at their reset values
- Reset mid-frame aborts the frame immediately (asynchronous). The first clock after release outputs position (0,0): frame_start=1 and the pattern is re-captured.
- Latency: video outputs lag the counters, `pixel_req`, `req_x` and `req_y` by exactly 1 cycle. Consequently:
  - `ext_rgb` must be valid in the same cycle `pixel_req`=1.
  - That value appears on RGB the next cycle, with BLANK=1.
- Simultaneous events:
  - At h=HTOTAL-1, v=VTOTAL-1 both counters wrap in the same edge.
  - The next output cycle carries both frame_start=1 and line_start=1.
- A `pattern_sel` change takes effect on the first active pixel of the next frame. A change in the capture cycle itself is taken.
- Frame period: HTOTAL×VTOTAL cycles, exactly. HS period: HTOTAL cycles.

## Test plan
Bench parameters: HDISP=16, VDISP=8, HFP=2, HPULSE=3, HBP=2, VFP=1, VPULSE=2, VBP=1, GRID=4. This gives HTOTAL=23, VTOTAL=12 and a 276-cycle frame.

1. **Reset and first frame.** Release reset. Required:
   - frame_start=1 in the first cycle, and period 276.
   - HS low for 3 cycles starting at output cycle 2 of each line.
   - VS low for lines 1–2.
   - BLANK=1 for exactly 16×8=128 cycles per frame.
2. **Grid, fg_color=24'h00FF00.** RGB=00FF00 at (0,y), (4,y), (x,0), (x,4); RGB=0 at (1,1); RGB=0 whenever BLANK=0.
3. **Bars and ramp.** Bars: pixels x=0..1 give FFFFFF and x=14..15 give 000000. Ramp: RGB at x=5 is 050505.
4. **External mode.** Drive ext_rgb={8'h00, req_y, req_x} (zero-extended). Required: RGB at the next cycle equals that value for all 128 pixels, and pixel_req leads BLANK by exactly 1 cycle.
5. **Mid-frame `pattern_sel` change, 0→1 at line 5.** Required: the remaining lines are still grid, and the next frame is bars.
6. **Polarity and reset abort.** Set HS_POL=1 and VS_POL=1: sync pulses are high, and idle levels in reset are 0. Separately, assert `pixel_rst_n` at cycle 150: outputs take their reset values asynchronously, and the frame restarts with frame_start after release.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// video_if: pixel-clock video bundle toward the DAC/LCD.
// The master drives sync, blank, colour and the forwarded clock.
interface video_if;
  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;

  modport master (
    output CLK, HS, VS, BLANK, RGB
  );

  modport slave (
    input CLK, HS, VS, BLANK, RGB
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing and test-pattern generator.
// Counters feed a registered HS/VS/BLANK/RGB stage one cycle behind.
module vga_timing_gen #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 12,
  parameter int VPULSE = 3,
  parameter int VBP    = 40,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int GRID   = 16
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst_n,
  input  logic [1:0]               pattern_sel,
  input  logic [23:0]              fg_color,
  input  logic [23:0]              ext_rgb,
  output logic                     pixel_req,
  output logic [$clog2(HDISP)-1:0] req_x,
  output logic [$clog2(VDISP)-1:0] req_y,
  output logic                     frame_start,
  output logic                     line_start,
  video_if.master                  video_ifm
);
  localparam int HSUP   = HFP + HPULSE + HBP;
  localparam int VSUP   = VFP + VPULSE + VBP;
  localparam int HTOTAL = HDISP + HSUP;
  localparam int VTOTAL = VDISP + VSUP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int XW     = $clog2(HDISP);
  localparam int YW     = $clog2(VDISP);
  localparam int BARW   = HDISP / 8;

  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_S0   = HW'(HFP);
  localparam logic [HW-1:0] H_S1   = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] H_SUP  = HW'(HSUP);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_S0   = VW'(VFP);
  localparam logic [VW-1:0] V_S1   = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] V_SUP  = VW'(VSUP);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [1:0]    r_pat;
  logic [23:0]   r_fg;
  logic          r_hs;
  logic          r_vs;
  logic          r_blank;
  logic          r_fs;
  logic          r_ls;
  logic [23:0]   r_rgb;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_top;
  logic          w_act;
  logic          w_hsync;
  logic          w_vsync;
  logic          w_grid;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic [31:0]   w_idx;
  logic [2:0]    w_bar;
  logic [23:0]   w_bar_rgb;
  logic [23:0]   w_pat_rgb;

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  assign w_top    = (r_h == '0) && (r_v == '0);
  assign w_act    = (r_h >= H_SUP) && (r_v >= V_SUP);
  assign w_hsync  = (r_h >= H_S0) && (r_h < H_S1);
  assign w_vsync  = (r_v >= V_S0) && (r_v < V_S1);

  assign w_x = w_act ? XW'(r_h - H_SUP) : '0;
  assign w_y = w_act ? YW'(r_v - V_SUP) : '0;

  assign pixel_req = w_act;
  assign req_x     = w_x;
  assign req_y     = w_y;

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // Pattern and colour only move at the top-left corner of a frame.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      r_pat <= 2'd0;
      r_fg  <= 24'hFFFFFF;
    end else if (w_top) begin
      r_pat <= pattern_sel;
      r_fg  <= fg_color;
    end
  end

  assign w_grid = ((32'(w_x) % 32'(GRID)) == 32'd0)
               || ((32'(w_y) % 32'(GRID)) == 32'd0);
  assign w_idx  = 32'(w_x) / 32'(BARW);
  assign w_bar  = (w_idx > 32'd7) ? 3'd7 : w_idx[2:0];

  always_comb begin
    w_bar_rgb = 24'h000000;
    unique case (w_bar)
      3'd0: w_bar_rgb = 24'hFFFFFF;
      3'd1: w_bar_rgb = 24'hFFFF00;
      3'd2: w_bar_rgb = 24'h00FFFF;
      3'd3: w_bar_rgb = 24'h00FF00;
      3'd4: w_bar_rgb = 24'hFF00FF;
      3'd5: w_bar_rgb = 24'hFF0000;
      3'd6: w_bar_rgb = 24'h0000FF;
      3'd7: w_bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    w_pat_rgb = 24'h000000;
    unique case (r_pat)
      2'd0: w_pat_rgb = w_grid ? r_fg : 24'h000000;
      2'd1: w_pat_rgb = w_bar_rgb;
      2'd2: w_pat_rgb = {3{8'(w_x)}};
      2'd3: w_pat_rgb = ext_rgb;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      r_hs    <= ~HS_POL;
      r_vs    <= ~VS_POL;
      r_blank <= 1'b0;
      r_rgb   <= 24'h000000;
      r_fs    <= 1'b0;
      r_ls    <= 1'b0;
    end else begin
      r_hs    <= w_hsync ? HS_POL : ~HS_POL;
      r_vs    <= w_vsync ? VS_POL : ~VS_POL;
      r_blank <= w_act;
      r_rgb   <= w_act ? w_pat_rgb : 24'h000000;
      r_fs    <= w_top;
      r_ls    <= (r_h == '0);
    end
  end

  assign frame_start     = r_fs;
  assign line_start      = r_ls;
  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = r_hs;
  assign video_ifm.VS    = r_vs;
  assign video_ifm.BLANK = r_blank;
  assign video_ifm.RGB   = r_rgb;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: frame-position model vs two DUTs (both polarities).
// Expected outputs come from linear frame position and pattern rules.
module tb_vga_timing_gen;
  localparam int HD = 16;
  localparam int VD = 8;
  localparam int HFP = 2;
  localparam int HPU = 3;
  localparam int HBP = 2;
  localparam int VFP = 1;
  localparam int VPU = 2;
  localparam int VBP = 1;
  localparam int HSU = HFP + HPU + HBP;
  localparam int VSU = VFP + VPU + VBP;
  localparam int HT = HD + HSU;
  localparam int VT = VD + VSU;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] fg_color = 24'h00FF00;
  logic [23:0] ext_rgb;
  logic [7:0]  r_rnd = 8'h00;

  logic       preq0, preq1, fs0, fs1, ls0, ls1;
  logic [3:0] rx0, rx1;
  logic [2:0] ry0, ry1;

  video_if vif0();
  video_if vif1();

  always #5 clk = ~clk;

  assign ext_rgb = {r_rnd, 9'd0, ry0, rx0};

  vga_timing_gen #(
    .HDISP(HD), .VDISP(VD),
    .HFP(HFP), .HPULSE(HPU), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPU), .VBP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .GRID(4)
  ) u_dut0 (
    .pixel_clk(clk), .pixel_rst_n(rst_n),
    .pattern_sel(pattern_sel), .fg_color(fg_color),
    .ext_rgb(ext_rgb), .pixel_req(preq0),
    .req_x(rx0), .req_y(ry0),
    .frame_start(fs0), .line_start(ls0),
    .video_ifm(vif0.master)
  );

  vga_timing_gen #(
    .HDISP(HD), .VDISP(VD),
    .HFP(HFP), .HPULSE(HPU), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPU), .VBP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .GRID(4)
  ) u_dut1 (
    .pixel_clk(clk), .pixel_rst_n(rst_n),
    .pattern_sel(pattern_sel), .fg_color(fg_color),
    .ext_rgb(ext_rgb), .pixel_req(preq1),
    .req_x(rx1), .req_y(ry1),
    .frame_start(fs1), .line_start(ls1),
    .video_ifm(vif1.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %h want %h",
               nm, $time, act, exp);
    end
  endtask

  logic [23:0] bars [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic logic [23:0] pat_rgb(
    input int p, input logic [23:0] col,
    input int x, input int y, input logic [23:0] ext);
    int b;
    case (p)
      0: return ((x % 4 == 0) || (y % 4 == 0)) ? col : 24'h0;
      1: begin
        b = x / (HD / 8);
        if (b > 7) b = 7;
        return bars[b];
      end
      2: return {3{8'(x)}};
      default: return ext;
    endcase
  endfunction

  // Model: pos is the counter position the next edge will output.
  int          pos = 0;
  int          o_pos = -1;
  int          m_pat = 0;
  logic [23:0] m_col = 24'hFFFFFF;
  logic        e_hs = 1'b1, e_vs = 1'b1;
  logic        e_blank = 1'b0, e_fs = 1'b0, e_ls = 1'b0;
  logic [23:0] e_rgb = 24'h0;

  always @(posedge clk or negedge rst_n) begin
    int h, v;
    bit act;
    if (!rst_n) begin
      pos = 0; o_pos = -1;
      m_pat = 0; m_col = 24'hFFFFFF;
      e_hs = 1'b1; e_vs = 1'b1;
      e_blank = 1'b0; e_rgb = 24'h0;
      e_fs = 1'b0; e_ls = 1'b0;
    end else begin
      h = pos % HT;
      v = pos / HT;
      if (pos == 0) begin
        m_pat = int'(pattern_sel);
        m_col = fg_color;
      end
      act = (h >= HSU) && (v >= VSU);
      e_hs = !((h >= HFP) && (h < HFP + HPU));
      e_vs = !((v >= VFP) && (v < VFP + VPU));
      e_blank = act;
      e_rgb = act ? pat_rgb(m_pat, m_col, h - HSU, v - VSU, ext_rgb)
                  : 24'h0;
      e_fs = (pos == 0);
      e_ls = (h == 0);
      o_pos = pos;
      pos = (pos + 1) % FRAME;
    end
  end

  logic prev_req = 1'b0;
  bit   have = 0;
  int   per = 0;
  int   nb = 0;

  always @(negedge clk) begin
    int h, v;
    bit act;
    h = pos % HT;
    v = pos / HT;
    act = (h >= HSU) && (v >= VSU);
    chk("clk_fwd", 32'(vif0.CLK), 32'(clk));
    chk("hs0", 32'(vif0.HS), 32'(e_hs));
    chk("hs1", 32'(vif1.HS), 32'(!e_hs));
    chk("vs0", 32'(vif0.VS), 32'(e_vs));
    chk("vs1", 32'(vif1.VS), 32'(!e_vs));
    chk("blank0", 32'(vif0.BLANK), 32'(e_blank));
    chk("blank1", 32'(vif1.BLANK), 32'(e_blank));
    chk("rgb0", 32'(vif0.RGB), 32'(e_rgb));
    chk("rgb1", 32'(vif1.RGB), 32'(e_rgb));
    chk("fs0", 32'(fs0), 32'(e_fs));
    chk("fs1", 32'(fs1), 32'(e_fs));
    chk("ls0", 32'(ls0), 32'(e_ls));
    chk("ls1", 32'(ls1), 32'(e_ls));
    chk("preq0", 32'(preq0), 32'(act));
    chk("preq1", 32'(preq1), 32'(act));
    chk("rx0", 32'(rx0), act ? h - HSU : 0);
    chk("ry0", 32'(ry0), act ? v - VSU : 0);
    chk("rx1", 32'(rx1), act ? h - HSU : 0);
    chk("ry1", 32'(ry1), act ? v - VSU : 0);
    if (o_pos >= 0) chk("req_lead", 32'(vif0.BLANK), 32'(prev_req));
    prev_req = preq0;
    if (!rst_n) begin
      have = 0;
    end else begin
      if (fs0) begin
        if (have) begin
          chk("frame_period", per, FRAME);
          chk("blank_count", nb, HD * VD);
        end
        have = 1; per = 0; nb = 0;
      end
      per++;
      if (vif0.BLANK) nb++;
    end
  end

  always @(negedge clk) r_rnd = 8'($urandom);

  task automatic wait_out(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_pos != p && n < 700);
    if (o_pos != p) chk("wait_out", o_pos, p);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #20;
    chk("rst_hs0", 32'(vif0.HS), 32'd1);
    chk("rst_hs1", 32'(vif1.HS), 32'd0);
    chk("rst_vs1", 32'(vif1.VS), 32'd0);
    chk("rst_rgb", 32'(vif0.RGB), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    wait_out(0);
    chk("first_fs", 32'(fs0), 32'd1);
    chk("first_ls", 32'(ls0), 32'd1);
    wait_out(1);
    chk("hs_idle", 32'(vif0.HS), 32'd1);
    wait_out(2);
    chk("hs_low2", 32'(vif0.HS), 32'd0);
    chk("hs1_hi2", 32'(vif1.HS), 32'd1);
    wait_out(4);
    chk("hs_low4", 32'(vif0.HS), 32'd0);
    wait_out(5);
    chk("hs_end5", 32'(vif0.HS), 32'd1);
    wait_out(23);
    chk("vs_line1", 32'(vif0.VS), 32'd0);
    chk("vs1_line1", 32'(vif1.VS), 32'd1);
    wait_out(69);
    chk("vs_line3", 32'(vif0.VS), 32'd1);
    wait_out(115);
    pattern_sel = 2'd1;
    wait_out(123);
    chk("grid_1_1", 32'(vif0.RGB), 32'h0);
    wait_out(145);
    chk("grid_0_2", 32'(vif0.RGB), 32'h00FF00);
    wait_out(193);
    chk("grid_2_4", 32'(vif0.RGB), 32'h00FF00);

    wait_out(99);
    chk("bar_x0", 32'(vif0.RGB), 32'hFFFFFF);
    wait_out(114);
    chk("bar_x15", 32'(vif0.RGB), 32'h000000);
    pattern_sel = 2'd2;
    wait_out(104);
    chk("ramp_x5", 32'(vif0.RGB), 32'h050505);
    pattern_sel = 2'd3;
    wait_out(0);
    wait_out(125);
    chk("ext_3_1", 32'(vif0.RGB[15:0]), 32'h0013);
    wait_out(275);

    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      fg_color = 24'($urandom);
      if ($urandom_range(0, 49) == 0)
        pattern_sel = 2'($urandom_range(0, 3));
    end

    pattern_sel = 2'd1;
    wait_out(150);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_hs0", 32'(vif0.HS), 32'd1);
    chk("abort_hs1", 32'(vif1.HS), 32'd0);
    chk("abort_vs1", 32'(vif1.VS), 32'd0);
    chk("abort_blk", 32'(vif0.BLANK), 32'd0);
    chk("abort_rgb", 32'(vif0.RGB), 32'd0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_out(0);
    chk("restart_fs", 32'(fs0), 32'd1);
    wait_out(99);
    chk("restart_bar", 32'(vif0.RGB), 32'hFFFFFF);
    repeat (300) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
